// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB per instruction and
// drives the datapath control bundle, with memory timeout, HALT and retire tracking.
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic             mem_ready,
  output logic             reg_dst,
  output logic             beq,
  output logic             reg_write,
  output logic             jump,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       alu_op,
  output logic             pc_write,
  output logic             ir_write,
  output logic             halted,
  output logic             illegal_op,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [3:0] OP_LW   = 4'h0;
  localparam logic [3:0] OP_SW   = 4'h1;
  localparam logic [3:0] OP_R    = 4'h2;
  localparam logic [3:0] OP_ADDI = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_J    = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [7:0]       wait_q, wait_d;
  logic             illegal_q, illegal_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic mem_timeout;

  // Ready in the final wait cycle wins over the timeout.
  assign mem_timeout = (state_q == S_MEM) && !mem_ready && (wait_q == WAIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= 4'h0;
      wait_q    <= 8'd0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    mem_err_d = mem_err_q;
    retired_d = retired_q + {{(CNT_W-1){1'b0}}, pc_write};
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        op_d    = opcode;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          OP_LW, OP_SW:  state_d = S_MEM;
          OP_R, OP_ADDI: state_d = S_WB;
          OP_BEQ, OP_J:  state_d = S_FETCH;
          OP_HALT:       state_d = S_HALT;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        wait_d = wait_q + 8'd1;
        if (mem_ready) begin
          wait_d  = 8'd0;
          state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        end else if (mem_timeout) begin
          wait_d    = 8'd0;
          mem_err_d = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset forces every strobe low immediately, even though FETCH would raise ir_write.
  always_comb begin
    reg_dst    = 1'b0;
    beq        = 1'b0;
    reg_write  = 1'b0;
    jump       = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_op     = 2'b00;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    halted     = 1'b0;
    if (!reset) begin
      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
        case (op_q)
          OP_LW, OP_SW, OP_ADDI: alu_src = 1'b1;
          OP_R: begin
            reg_dst = 1'b1;
            alu_op  = 2'b10;
          end
          OP_BEQ:  alu_op = 2'b01;
          default: alu_op = 2'b00;
        endcase
      end
      case (state_q)
        S_FETCH: ir_write = 1'b1;
        S_EXEC: begin
          case (op_q)
            OP_LW, OP_SW, OP_R, OP_ADDI, OP_HALT: pc_write = 1'b0;
            OP_BEQ: begin
              beq      = 1'b1;
              pc_write = 1'b1;
            end
            OP_J: begin
              jump     = 1'b1;
              pc_write = 1'b1;
            end
            default: pc_write = 1'b1;
          endcase
        end
        S_MEM: begin
          mem_read  = (op_q == OP_LW);
          mem_write = (op_q == OP_SW);
          pc_write  = (mem_ready && op_q == OP_SW) || mem_timeout;
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (op_q == OP_LW);
          pc_write   = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        default: ir_write = 1'b0;
      endcase
    end
  end

  assign illegal_op = illegal_q;
  assign mem_err    = mem_err_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: per-instruction expectations from an
// instruction-level model, checked by a monitor at each pc_write.
module tb_multicycle_ctrl_fsm;
  localparam int T  = 15;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    opcode = 4'h0;
  logic          mem_ready = 1'b0;
  logic          reg_dst, beq, reg_write, jump, alu_src, mem_to_reg, mem_read, mem_write;
  logic [1:0]    alu_op;
  logic          pc_write, ir_write, halted, illegal_op, mem_err;
  logic [CW-1:0] retired;
  logic [18:0]   all_out;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .reg_dst(reg_dst), .beq(beq), .reg_write(reg_write), .jump(jump),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
    .mem_write(mem_write), .alu_op(alu_op), .pc_write(pc_write),
    .ir_write(ir_write), .halted(halted), .illegal_op(illegal_op),
    .mem_err(mem_err), .retired(retired)
  );

  assign all_out = {reg_dst, beq, reg_write, jump, alu_src, mem_to_reg, mem_read,
                    mem_write, alu_op, pc_write, ir_write, halted, illegal_op,
                    mem_err, retired};

  typedef struct {
    int len; int rw; int m2r; int rdst; int mrd; int mwr; int bq; int jp;
    int aluop; int alusrc; int merr; int ill; int ret;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   m_ret = 0;
  int   m_merr = 0;
  int   m_ill = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level model: length in cycles and strobe counts follow directly
  // from the opcode and the MEM cycle on which memory becomes ready.
  task automatic issue(input logic [3:0] op, input int d);
    exp_t e;
    bit   rdy;
    int   m;
    rdy = (d <= T);
    m   = rdy ? d : T;
    e   = '{default: 0};
    case (op)
      4'h0: begin
        e.alusrc = 1; e.mrd = m;
        if (rdy) begin e.len = 4 + d; e.rw = 1; e.m2r = 1; end
        else begin e.len = 3 + T; m_merr = 1; end
      end
      4'h1: begin
        e.alusrc = 1; e.mwr = m; e.len = 3 + m;
        if (!rdy) m_merr = 1;
      end
      4'h2: begin e.len = 4; e.rw = 1; e.rdst = 2; e.aluop = 2; end
      4'h3: begin e.len = 4; e.rw = 1; e.alusrc = 1; end
      4'h4: begin e.len = 3; e.bq = 1; e.aluop = 1; end
      4'h5: begin e.len = 3; e.jp = 1; end
      default: begin e.len = 3; m_ill = 1; end
    endcase
    m_ret  = (m_ret + 1) % (1 << CW);
    e.merr = m_merr;
    e.ill  = m_ill;
    e.ret  = m_ret;
    exp_q.push_back(e);
    opcode = op;
    for (int c = 1; c <= e.len; c++) begin
      mem_ready = (op == 4'h0 || op == 4'h1) && (c >= 3 + d);
      step();
    end
    mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    mon_en    = 1'b0;
    mem_ready = 1'b0;
    reset     = 1'b1;
    #1;
    chk("reset_outputs_zero", int'(all_out), 0);
    step();
    step();
    m_ret  = 0;
    m_merr = 0;
    m_ill  = 0;
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  // Monitor: accumulate strobes between ir_write and pc_write, then compare.
  initial begin
    int   cyc, rw, m2r, rdst, mrd, mwr, bq, jp, both, aop, asrc;
    bit   pend;
    exp_t e, pe;
    cyc = 0; rw = 0; m2r = 0; rdst = 0; mrd = 0; mwr = 0; bq = 0; jp = 0;
    both = 0; aop = 0; asrc = 0; pend = 1'b0;
    forever begin
      @(negedge clk);
      if (reset || !mon_en) begin
        pend = 1'b0;
        cyc  = 0;
      end else begin
        if (pend) begin
          chk("mem_err_after", int'(mem_err), pe.merr);
          chk("illegal_after", int'(illegal_op), pe.ill);
          chk("retired_after", int'(retired), pe.ret);
          chk("fetch_after_pc_write", int'(ir_write), 1);
          pend = 1'b0;
        end
        if (ir_write) begin
          cyc = 1; rw = 0; m2r = 0; rdst = 0; mrd = 0; mwr = 0; bq = 0; jp = 0;
          both = 0;
        end else begin
          cyc++;
        end
        rw   += int'(reg_write);
        m2r  += int'(mem_to_reg);
        rdst += int'(reg_dst);
        mrd  += int'(mem_read);
        mwr  += int'(mem_write);
        bq   += int'(beq);
        jp   += int'(jump);
        both += int'(mem_read & mem_write);
        if (cyc == 3) begin
          aop  = int'(alu_op);
          asrc = int'(alu_src);
        end
        if (pc_write) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pc_write", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk("instr_cycles", cyc, e.len);
            chk("reg_write_cycles", rw, e.rw);
            chk("mem_to_reg_cycles", m2r, e.m2r);
            chk("reg_dst_cycles", rdst, e.rdst);
            chk("mem_read_cycles", mrd, e.mrd);
            chk("mem_write_cycles", mwr, e.mwr);
            chk("beq_cycles", bq, e.bq);
            chk("jump_cycles", jp, e.jp);
            chk("rd_wr_overlap", both, 0);
            chk("exec_alu_op", aop, e.aluop);
            chk("exec_alu_src", asrc, e.alusrc);
            pe   = e;
            pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int irw, pcw, hc;
    int r;

    // Mixed sequence with zero-wait memory
    do_reset();
    issue(4'h2, 1);
    issue(4'h3, 1);
    issue(4'h0, 1);
    issue(4'h1, 1);
    issue(4'h5, 1);
    // Slow LW, timed-out SW, then a normal instruction
    issue(4'h0, 3);
    issue(4'h1, 99);
    issue(4'h2, 1);

    // Reserved opcode followed by BEQ
    do_reset();
    issue(4'h8, 1);
    issue(4'h4, 1);
    @(negedge clk);
    chk("illegal_sticky", int'(illegal_op), 1);
    chk("retired_two", int'(retired), 2);

    // Counter wrap
    do_reset();
    for (int i = 0; i < 17; i++) issue(4'h5, 1);
    @(negedge clk);
    chk("retired_wrap", int'(retired), 1);

    // Randomized instruction stream
    do_reset();
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 9));
      if (r > 5) r = int'($urandom_range(6, 14));
      issue(4'(r), int'($urandom_range(1, 18)));
    end

    // HALT is absorbing
    do_reset();
    issue(4'h5, 1);
    opcode = 4'hF;
    step();
    step();
    @(negedge clk);
    chk("halt_not_in_exec", int'(halted), 0);
    step();
    @(negedge clk);
    chk("halted_after_exec", int'(halted), 1);
    irw = 0; pcw = 0; hc = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      opcode = 4'($urandom);
      @(negedge clk);
      irw += int'(ir_write);
      pcw += int'(pc_write);
      hc  += int'(halted);
    end
    chk("halt_ir_write", irw, 0);
    chk("halt_pc_write", pcw, 0);
    chk("halt_held", hc, 50);
    chk("halt_retired_hold", int'(retired), 1);

    // Asynchronous reset in the middle of a stalled LW
    do_reset();
    mon_en    = 1'b0;
    opcode    = 4'h0;
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    @(negedge clk);
    chk("mem_read_before_reset", int'(mem_read), 1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", int'(all_out), 0);
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("fetch_after_reset", int'(ir_write), 1);
    chk("no_pc_write_in_fetch", int'(pc_write), 0);
    @(negedge clk);
    chk("decode_after_reset", int'(ir_write), 0);
    chk("no_mem_read_in_decode", int'(mem_read), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
